lane_neuron: RTL

LANE_NEURON -- requirements
Module: lane_neuron

---
 rtl/lane_neuron.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lane_neuron.sv
// lane_neuron: fixed-point neuron, NUM_LANES multiply-accumulates per cycle, then an activation.
// Define NEURON_SATURATE_EN to clamp an out-of-range sum instead of wrapping it.
package lane_neuron_pkg;
  typedef enum logic [1:0] {NONE, RELU, HARD_SIGMOID} activation_e;
endpackage

module lane_neuron
  import lane_neuron_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = 4,
  parameter int unsigned NUM_LANES      = 1,
  parameter activation_e ACTIVATION     = RELU,
  parameter int unsigned INTEGER_WIDTH  = 8,
  parameter int unsigned FRACTION_WIDTH = 8,
  localparam int unsigned W = INTEGER_WIDTH + FRACTION_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inputs_ready,
  input  logic [NUM_INPUTS-1:0][W-1:0] inputs,
  input  logic [NUM_INPUTS-1:0][W-1:0] weights,
  input  logic [W-1:0]                 bias,
  output logic                         busy,
  output logic                         output_ready,
  output logic [W-1:0]                 out,
  output logic                         overflow
);

  localparam int unsigned G         = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
  localparam int unsigned PAD_N     = G * NUM_LANES;
  localparam int unsigned PAD_BITS  = PAD_N * W;
  localparam int unsigned LANE_BITS = NUM_LANES * W;
  localparam int unsigned PROD_W    = 2 * W;
  localparam int unsigned ACC_W     = 2 * W + $clog2(NUM_INPUTS + 1);
  localparam int unsigned GW        = (G > 1) ? $clog2(G) : 1;

  localparam logic [W-1:0]        MAX_V  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        MIN_V  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   ONE_X  = (W+1)'(1) << FRACTION_WIDTH;
  localparam logic signed [W:0]   HALF_X = (W+1)'(1) << (FRACTION_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUMULATE, S_ACTIVATE, S_DONE} state_e;

  state_e state, state_next;
  logic   accept;
  logic   last_group;

  logic [PAD_N-1:0][W-1:0]   cap_in, cap_w;
  logic [GW-1:0]             group;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [PROD_W-1:0]  prod [NUM_LANES];
  logic signed [ACC_W-1:0]   shifted;
  logic [ACC_W-W:0]          range_hi;
  logic                      range_ovf;
  logic [W-1:0]              reduced;
  logic signed [W:0]         hs;
  logic [W-1:0]              activated;

  assign last_group = (group == GW'(G - 1));

  // State register; busy is registered from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_ACCUMULATE) || (state_next == S_ACTIVATE);
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (inputs_ready) begin
          accept     = 1'b1;
          state_next = S_ACCUMULATE;
        end
      end
      S_ACCUMULATE: if (last_group) state_next = S_ACTIVATE;
      S_ACTIVATE:   state_next = S_DONE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Lanes always read the bottom NUM_LANES captured elements; the capture shifts down per group.
  always_comb begin
    lane_sum = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      prod[l]  = $signed(cap_in[l]) * $signed(cap_w[l]);
      lane_sum = lane_sum + ACC_W'(prod[l]);
    end
  end

  always_comb begin
    shifted   = acc >>> FRACTION_WIDTH;
    range_hi  = shifted[ACC_W-1:W-1];
    range_ovf = !((&range_hi) || !(|range_hi));
`ifdef NEURON_SATURATE_EN
    reduced   = range_ovf ? (shifted[ACC_W-1] ? MIN_V : MAX_V) : shifted[W-1:0];
`else
    reduced   = shifted[W-1:0];
`endif
    hs        = ($signed({reduced[W-1], reduced}) >>> 2) + HALF_X;
    activated = reduced;
    case (ACTIVATION)
      NONE:         activated = reduced;
      RELU:         activated = reduced[W-1] ? '0 : reduced;
      HARD_SIGMOID: begin
        if (hs[W])          activated = '0;
        else if (hs > ONE_X) activated = ONE_X[W-1:0];
        else                 activated = hs[W-1:0];
      end
      default:      activated = reduced;
    endcase
  end

  // Datapath: capture, accumulate, activate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_in       <= '0;
      cap_w        <= '0;
      acc          <= '0;
      group        <= '0;
      out          <= '0;
      output_ready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cap_in       <= PAD_BITS'(inputs);
            cap_w        <= PAD_BITS'(weights);
            acc          <= ACC_W'($signed(bias)) <<< FRACTION_WIDTH;
            group        <= '0;
            output_ready <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        S_ACCUMULATE: begin
          acc    <= acc + lane_sum;
          cap_in <= cap_in >> LANE_BITS;
          cap_w  <= cap_w >> LANE_BITS;
          group  <= group + GW'(1);
        end
        S_ACTIVATE: begin
          out          <= activated;
          overflow     <= range_ovf;
          output_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
